// File: rtl/uart_mem_writer_if.sv
// uart_mem_writer_if
//   Groups the byte-stream input from uart_rx and the memory-write / status
//   outputs of uart_mem_writer into one bundle.
//
//   Parameters: ADDR_W, DATA_W -- must match the uart_mem_writer instance.
//
//   Signals:
//     rcv_i        one-cycle strobe, byte_i is valid
//     byte_i       received byte
//     mw_o         one-cycle memory-write strobe
//     address_o    write address, held until the next commit
//     data_o       write data, held until the next commit
//     busy_o       decoder is inside a packet
//     err_o        one-cycle error pulse (checksum or timeout)
//     pkt_count_o  committed packets, wraps at 2^16
//     err_count_o  errors, saturates at 255
//     last_byte_o  last received byte, for the board LEDs
//
//   Modports:
//     slave  -- the decoder (consumes bytes, produces writes and status)
//     master -- whoever feeds bytes and observes the writes
interface uart_mem_writer_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              rcv_i;
  logic [7:0]        byte_i;
  logic              mw_o;
  logic [ADDR_W-1:0] address_o;
  logic [DATA_W-1:0] data_o;
  logic              busy_o;
  logic              err_o;
  logic [15:0]       pkt_count_o;
  logic [7:0]        err_count_o;
  logic [7:0]        last_byte_o;

  modport slave (
    input  rcv_i, byte_i,
    output mw_o, address_o, data_o, busy_o, err_o,
           pkt_count_o, err_count_o, last_byte_o
  );

  modport master (
    output rcv_i, byte_i,
    input  mw_o, address_o, data_o, busy_o, err_o,
           pkt_count_o, err_count_o, last_byte_o
  );
endinterface

// File: rtl/uart_mem_writer.sv
// uart_mem_writer
//   Assembles framed byte packets from uart_rx into single-cycle memory-write
//   transactions for the sprite/memory port of the graphic controller.
//
//   Packet (MSB first): SYNC_BYTE, AB address bytes, DB data bytes and,
//   when UART_MW_CHECKSUM_EN is defined, one checksum byte (8-bit sum of the
//   address and data bytes). Without the macro the checksum state, the
//   accumulator and the comparator are not built and only timeouts are errors.
//
//   Parameters:
//     ADDR_W       address width (AB = ceil(ADDR_W/8) address bytes)
//     DATA_W       data width    (DB = ceil(DATA_W/8) data bytes)
//     SYNC_BYTE    packet start marker
//     TIMEOUT_CYC  max idle gap inside a packet, in clk cycles (>= 2)
//
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  uart_mem_writer_if.slave: rcv_i/byte_i in; mw_o, address_o,
//          data_o, busy_o, err_o, pkt_count_o, err_count_o, last_byte_o out
module uart_mem_writer #(
  parameter int         ADDR_W      = 30,
  parameter int         DATA_W      = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input logic              clk,
  input logic              rst,
  uart_mem_writer_if.slave bus
);

  localparam int AB    = (ADDR_W + 7) / 8;
  localparam int DB    = (DATA_W + 7) / 8;
  localparam int MAXB  = (AB > DB) ? AB : DB;
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
`ifdef UART_MW_CHECKSUM_EN
    S_DATA = 2'd2,
    S_CSUM = 2'd3
`else
    S_DATA = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mw_q, mw_d;
  logic              err_q, err_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [7:0]        last_byte_q, last_byte_d;
`ifdef UART_MW_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Shifting the new byte in at the bottom and truncating drops the surplus
  // high bits of the first byte when the width is not a multiple of 8.
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] data_shift;
  assign addr_shift = ADDR_W'({addr_sh_q, bus.byte_i});
  assign data_shift = DATA_W'({data_sh_q, bus.byte_i});

  logic commit;
  logic fail;

  // Next-state and output logic. A received byte always takes priority over
  // the timeout, so the timeout branch is only reachable when rcv_i is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    address_d   = address_q;
    data_d      = data_q;
    mw_d        = 1'b0;
    err_d       = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_byte_d = last_byte_q;
`ifdef UART_MW_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    commit      = 1'b0;
    fail        = 1'b0;

    if (bus.rcv_i) begin
      last_byte_d = bus.byte_i;
    end

    // Inter-byte timeout: held at zero while idle, cleared by every byte.
    if (state_q == S_IDLE || bus.rcv_i) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT_CYC)) begin
      to_d    = '0;
      state_d = S_IDLE;
      fail    = 1'b1;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    if (bus.rcv_i) begin
      case (state_q)
        S_IDLE: begin
          if (bus.byte_i == SYNC_BYTE) begin
            state_d = S_ADDR;
            cnt_d   = '0;
`ifdef UART_MW_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end
        end
        S_ADDR: begin
          addr_sh_d = addr_shift;
`ifdef UART_MW_CHECKSUM_EN
          csum_d    = csum_q + bus.byte_i;
`endif
          if (cnt_q == CNT_W'(AB - 1)) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          data_sh_d = data_shift;
`ifdef UART_MW_CHECKSUM_EN
          csum_d    = csum_q + bus.byte_i;
`endif
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d = '0;
`ifdef UART_MW_CHECKSUM_EN
            state_d = S_CSUM;
`else
            // The last data byte is still in flight, so take it from the
            // shifter input rather than the register.
            state_d   = S_IDLE;
            address_d = addr_sh_q;
            data_d    = data_shift;
            commit    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_MW_CHECKSUM_EN
        S_CSUM: begin
          state_d = S_IDLE;
          if (bus.byte_i == csum_q) begin
            address_d = addr_sh_q;
            data_d    = data_sh_q;
            commit    = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (commit) begin
      mw_d      = 1'b1;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (fail) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; a reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      address_q   <= '0;
      data_q      <= '0;
      mw_q        <= 1'b0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      last_byte_q <= '0;
`ifdef UART_MW_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      address_q   <= address_d;
      data_q      <= data_d;
      mw_q        <= mw_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      last_byte_q <= last_byte_d;
`ifdef UART_MW_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.mw_o        = mw_q;
  assign bus.address_o   = address_q;
  assign bus.data_o      = data_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.err_o       = err_q;
  assign bus.pkt_count_o = pkt_cnt_q;
  assign bus.err_count_o = err_cnt_q;
  assign bus.last_byte_o = last_byte_q;

endmodule

// File: tb/tb_uart_mem_writer.sv
// tb_uart_mem_writer
//   Directed and randomized packets driven into uart_mem_writer, with the
//   expected write/error behaviour computed from whole packets (byte lists,
//   plain sums and masks). Works with or without UART_MW_CHECKSUM_EN.
module tb_uart_mem_writer;

  localparam int         ADDR_W = 30;
  localparam int         DATA_W = 32;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         TO     = 40;
  localparam int         AB     = (ADDR_W + 7) / 8;
  localparam int         DB     = (DATA_W + 7) / 8;
  localparam logic [63:0] AMASK = (64'd1 << ADDR_W) - 64'd1;
  localparam logic [63:0] DMASK = (64'd1 << DATA_W) - 64'd1;
`ifdef UART_MW_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_mem_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  uart_mem_writer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] expPkt = '0;
  logic [7:0]  expErrCnt = '0;
  logic [63:0] expAddr = '0;
  logic [63:0] expData = '0;
  logic [7:0]  expLast = '0;
  bit          curMw = 1'b0;
  bit          curErr = 1'b0;
  int          expMwPulses = 0;
  int          expErrPulses = 0;

  // Pulse counters observed on the falling edge
  int mwSeen = 0;
  int errSeen = 0;
  always @(negedge clk) begin
    if (bus.mw_o === 1'b1) mwSeen++;
    if (bus.err_o === 1'b1) errSeen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one byte after 'gap' idle cycles; returns on the falling edge right
  // after the sampling edge, where registered results are already visible.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rcv_i  = 1'b1;
    bus.byte_i = b;
    @(negedge clk);
    bus.rcv_i  = 1'b0;
    bus.byte_i = 8'($urandom);
  endtask

  task automatic noteError();
    curErr = 1'b1;
    expErrPulses++;
    if (expErrCnt != 8'hFF) expErrCnt = expErrCnt + 8'd1;
  endtask

  task automatic sendPacket(input logic [63:0] a, input logic [63:0] d,
                            input bit corrupt, input int gapLo, input int gapHi);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'd0;
    b = SYNC;
    applyStimulus(b, $urandom_range(gapHi, gapLo));
    for (int i = AB - 1; i >= 0; i--) begin
      b = 8'(a >> (8 * i));
      sum = sum + b;
      applyStimulus(b, $urandom_range(gapHi, gapLo));
    end
    for (int i = DB - 1; i >= 0; i--) begin
      b = 8'(d >> (8 * i));
      sum = sum + b;
      applyStimulus(b, $urandom_range(gapHi, gapLo));
    end
    if (CSUM_EN) begin
      b = corrupt ? sum + 8'd1 : sum;
      applyStimulus(b, $urandom_range(gapHi, gapLo));
    end
    expLast = b;
    curMw  = 1'b0;
    curErr = 1'b0;
    if (CSUM_EN && corrupt) begin
      noteError();
    end else begin
      curMw   = 1'b1;
      expMwPulses++;
      expPkt  = expPkt + 16'd1;
      expAddr = a & AMASK;
      expData = d & DMASK;
    end
  endtask

  task automatic checkPacket(input string tag);
    checkOutput({tag, "_mw"},      64'(bus.mw_o),        64'(curMw));
    checkOutput({tag, "_err"},     64'(bus.err_o),       64'(curErr));
    checkOutput({tag, "_addr"},    64'(bus.address_o),   expAddr);
    checkOutput({tag, "_data"},    64'(bus.data_o),      expData);
    checkOutput({tag, "_pkt"},     64'(bus.pkt_count_o), 64'(expPkt));
    checkOutput({tag, "_errcnt"},  64'(bus.err_count_o), 64'(expErrCnt));
    checkOutput({tag, "_busy"},    64'(bus.busy_o),      64'd0);
    checkOutput({tag, "_last"},    64'(bus.last_byte_o), 64'(expLast));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mw"},     64'(bus.mw_o),        64'd0);
    checkOutput({tag, "_err"},    64'(bus.err_o),       64'd0);
    checkOutput({tag, "_addr"},   64'(bus.address_o),   64'd0);
    checkOutput({tag, "_data"},   64'(bus.data_o),      64'd0);
    checkOutput({tag, "_pkt"},    64'(bus.pkt_count_o), 64'd0);
    checkOutput({tag, "_errcnt"}, 64'(bus.err_count_o), 64'd0);
    checkOutput({tag, "_busy"},   64'(bus.busy_o),      64'd0);
    checkOutput({tag, "_last"},   64'(bus.last_byte_o), 64'd0);
  endtask

  initial begin
    int waited;
    logic [7:0] junk;

    // Reset
    rst        = 1'b1;
    bus.rcv_i  = 1'b0;
    bus.byte_i = 8'h00;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Known packet: address 0x10, data 0xDEADBEEF, checksum 0x48
    sendPacket(64'h0000_0010, 64'hDEAD_BEEF, 1'b0, 0, 0);
    checkPacket("known");
    @(negedge clk);
    checkOutput("known_mw_single", 64'(bus.mw_o), 64'd0);

    // Same packet with a wrong checksum byte (commits when no checksum)
    sendPacket(64'h0000_0010, 64'hDEAD_BEEF, 1'b1, 0, 0);
    checkPacket("badsum");
    @(negedge clk);

    // Leading junk before a valid packet is ignored
    applyStimulus(8'h3C, 0);
    applyStimulus(8'h5A, 0);
    checkOutput("junk_busy", 64'(bus.busy_o), 64'd0);
    sendPacket(64'h1234_5678, 64'h0BAD_F00D, 1'b0, 0, 1);
    checkPacket("junk");

    // Timeout: three bytes then silence
    applyStimulus(SYNC, 2);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("to_busy_before", 64'(bus.busy_o), 64'd1);
    waited = 0;
    while (bus.err_o !== 1'b1 && waited < TO + 10) begin
      @(negedge clk);
      waited++;
    end
    curMw = 1'b0;
    noteError();
    checkOutput("to_latency", 64'(waited), 64'(TO + 1));
    checkOutput("to_busy_after", 64'(bus.busy_o), 64'd0);
    checkOutput("to_errcnt", 64'(bus.err_count_o), 64'(expErrCnt));
    checkOutput("to_mw", 64'(bus.mw_o), 64'd0);
    sendPacket(64'hCAFE_0001, 64'h1111_2222, 1'b0, 0, 2);
    checkPacket("after_to");

    // Each byte arrives exactly in the last cycle before the timeout fires
    sendPacket(64'h0000_00A5, 64'hA5A5_A5A5, 1'b0, TO, TO);
    checkPacket("edge_gap");

    // Back to back: second SYNC strobed in the mw_o cycle of the first
    sendPacket(64'h0101_0101, 64'h2020_2020, 1'b0, 0, 0);
    checkPacket("b2b_first");
    sendPacket(64'h3FFF_FFFF, 64'hFFFF_FFFF, 1'b0, 0, 0);
    checkPacket("b2b_second");

    // Randomized packets with optional junk, gaps and corruption
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h00;
        applyStimulus(junk, 0);
      end
      sendPacket({$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(2, 0) == 0), 0, 3);
      checkPacket("rand");
    end

    // Reset after the fifth byte of a packet
    applyStimulus(SYNC, 1);
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 0);
    checkOutput("midrst_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midrst");
    rst = 1'b0;
    expPkt = '0; expErrCnt = '0; expAddr = '0; expData = '0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_quiet_mw", 64'(bus.mw_o), 64'd0);
    checkOutput("midrst_quiet_err", 64'(bus.err_o), 64'd0);
    sendPacket(64'h0ABC_DEF0, 64'h7654_3210, 1'b0, 0, 1);
    checkPacket("after_rst");
    repeat (2) @(negedge clk);

    // No stray pulses anywhere in the run
    checkOutput("total_mw", 64'(mwSeen), 64'(expMwPulses));
    checkOutput("total_err", 64'(errSeen), 64'(expErrPulses));

    $display("[TB] CSUM_EN=%0d", CSUM_EN);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
